// File: rtl/epsilon_pkg.sv
// Shared constants and helpers for the epsilon sampler: mode encoding, LFSR polynomial, seed spreading.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package epsilon_pkg;

    localparam logic [1:0] MODE_MAG     = 2'd0;
    localparam logic [1:0] MODE_SIGNED  = 2'd1;
    localparam logic [1:0] MODE_UNIFORM = 2'd2;

    localparam logic [15:0] LFSR_POLY        = 16'hB400;
    localparam logic [15:0] SEED_SPREAD      = 16'h9E37;
    localparam logic [15:0] EPS_DEFAULT_SEED = 16'h0001;

    // Decorrelate channels by XORing a per-channel multiple of a spread constant;
    // the all-zero LFSR state is a lock-up state, so it is replaced by 1.
    function automatic logic [15:0] chan_seed(input logic [15:0] seed, input int unsigned ch);
        logic [15:0] spread;
        logic [15:0] s;
        spread = 16'(ch * 32'(SEED_SPREAD));
        s      = seed ^ spread;
        if (s == 16'h0000) begin
            s = 16'h0001;
        end
        return s;
    endfunction

    // One Galois step, right-shifting, feedback taps applied when the shifted-out bit is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/epsilon_lfsr.sv
// One 16-bit Galois LFSR channel with reseed; exposes the current state combinationally.
// Latency: load/step take effect on the next rising edge.
// Backpressure: advances only when step_i is high; load_i overrides step_i.
module epsilon_lfsr
    import epsilon_pkg::*;
#(
    parameter logic [15:0] RST_STATE = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Reseed wins over stepping; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    // State register; reset restores the channel's derived default seed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/epsilon_sampler.sv
// Multi-channel epsilon sampler: per-channel LFSR indexes a shared writable quantile LUT.
// Latency: one cycle from an enabled fire to out_valid/out_data; one vector per cycle.
// Backpressure: out_data/out_valid held while out_valid && !out_ready; LFSRs stall with them.
module epsilon_sampler #(
    parameter int          NUM_CH       = 4,
    parameter int          BITSIZE      = 20,
    parameter int          INDEX_BITS   = 5,
    parameter int          LFSR_W       = 16,
    parameter logic [15:0] DEFAULT_SEED = epsilon_pkg::EPS_DEFAULT_SEED
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic                      seed_load,
    input  logic [LFSR_W-1:0]         seed,
    input  logic                      lut_we,
    input  logic [INDEX_BITS-1:0]     lut_addr,
    input  logic [BITSIZE-1:0]        lut_wdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*BITSIZE-1:0] out_data
);

    import epsilon_pkg::*;

    localparam int LUT_DEPTH = 1 << INDEX_BITS;

    logic [BITSIZE-1:0]        lut_q [LUT_DEPTH];
    logic                      out_valid_q;
    logic [NUM_CH*BITSIZE-1:0] out_data_q;
    logic [NUM_CH*BITSIZE-1:0] out_data_d;
    logic                      fire;

    // A new vector is produced when enabled and the output slot is free or being drained.
    assign fire = enable && (!out_valid_q || out_ready);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] RST_S = chan_seed(DEFAULT_SEED, c);

        logic [LFSR_W-1:0]     st;
        logic [LFSR_W-1:0]     load_val;
        logic [INDEX_BITS-1:0] idx;
        logic [BITSIZE-1:0]    mag;
        logic [BITSIZE-1:0]    uni;
        logic [BITSIZE-1:0]    smp;

        assign load_val = chan_seed(seed, c);

        epsilon_lfsr #(
            .RST_STATE (RST_S)
        ) u_lfsr (
            .clk_i      (clk),
            .rst_i      (rst),
            .load_i     (seed_load),
            .load_val_i (load_val),
            .step_i     (fire),
            .state_o    (st)
        );

        assign idx = st[LFSR_W-1 -: INDEX_BITS];
        assign mag = lut_q[idx];

        if (BITSIZE >= LFSR_W) begin : g_uni_ext
            assign uni = BITSIZE'(st);
        end else begin : g_uni_trunc
            assign uni = st[LFSR_W-1 -: BITSIZE];
        end

        // Map the current state to a sample in the requested mode; code 3 behaves as MAG.
        always_comb begin
            smp = mag;
            case (mode)
                MODE_SIGNED:  smp = st[0] ? ({BITSIZE{1'b0}} - mag) : mag;
                MODE_UNIFORM: smp = uni;
                default:      smp = mag;
            endcase
        end

        assign out_data_d[c*BITSIZE +: BITSIZE] = smp;
    end

    // Quantile LUT: writes land after the edge, so same-cycle reads see the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_addr] <= lut_wdata;
        end
    end

    // Output slot: reseed discards any pending vector but leaves the data bits alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (seed_load) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_epsilon_sampler.sv
module tb_epsilon_sampler;

    localparam int NCH = 4;
    localparam int BW  = 20;
    localparam int IB  = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic            seed_load = 1'b0;
    logic [15:0]     seed = 16'h0001;
    logic            lut_we = 1'b0;
    logic [IB-1:0]   lut_addr = '0;
    logic [BW-1:0]   lut_wdata = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [NCH*BW-1:0] out_data;

    int total = 0;
    int bad   = 0;

    epsilon_sampler dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .seed_load (seed_load),
        .seed      (seed),
        .lut_we    (lut_we),
        .lut_addr  (lut_addr),
        .lut_wdata (lut_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    logic [15:0]       m_st  [NCH];
    logic [BW-1:0]     m_lut [32];
    logic              m_vld = 1'b0;
    logic [NCH*BW-1:0] exp_q [$];
    logic [NCH*BW-1:0] exp_v;

    function automatic logic [15:0] ref_seed(input logic [15:0] s, input int c);
        logic [31:0] p;
        logic [15:0] r;
        p = c * 32'h0000_9E37;
        r = s ^ p[15:0];
        if (r == 16'h0) r = 16'h0001;
        return r;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [BW-1:0] ref_map(input logic [15:0] s, input logic [1:0] md);
        logic [BW-1:0] m;
        m = m_lut[s[15:11]];
        if (md == 2'd1) return s[0] ? (20'h00000 - m) : m;
        if (md == 2'd2) return {4'h0, s};
        return m;
    endfunction

    function automatic logic [BW-1:0] ch(input int c);
        return out_data[c*BW +: BW];
    endfunction

    // Monitor: compare against the model, then predict the effect of the coming edge.
    always @(negedge clk) begin
        total++;
        if (out_valid !== m_vld) begin
            bad++;
            $display("FAIL sb_valid t=%0t got=%b exp=%b", $time, out_valid, m_vld);
        end
        if (m_vld && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty t=%0t got=%h exp=<none>", $time, out_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (out_data !== exp_v) begin
                    bad++;
                    $display("FAIL sb_data t=%0t got=%h exp=%h", $time, out_data, exp_v);
                end
            end
        end
        if (rst) begin
            m_vld = 1'b0;
            exp_q.delete();
            for (int i = 0; i < 32; i++) m_lut[i] = '0;
            for (int c = 0; c < NCH; c++) m_st[c] = ref_seed(16'h0001, c);
        end else begin
            if (seed_load) begin
                m_vld = 1'b0;
                exp_q.delete();
                for (int c = 0; c < NCH; c++) m_st[c] = ref_seed(seed, c);
            end else if (enable && (!m_vld || out_ready)) begin
                for (int c = 0; c < NCH; c++) exp_v[c*BW +: BW] = ref_map(m_st[c], mode);
                exp_q.push_back(exp_v);
                for (int c = 0; c < NCH; c++) m_st[c] = ref_step(m_st[c]);
                m_vld = 1'b1;
            end else if (m_vld && out_ready) begin
                m_vld = 1'b0;
            end
            if (lut_we) m_lut[lut_addr] = lut_wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [15:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic program_lut();
        for (int i = 0; i < 32; i++) begin
            lut_we    = 1'b1;
            lut_addr  = IB'(i);
            lut_wdata = BW'(i * 16);
            tick();
        end
        lut_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", out_valid);
        end
        total++;
        if (out_data !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", out_data);
        end
    endtask

    task automatic test_mag();
        mode = 2'd0;
        do_seed(16'h0001);
        enable = 1'b1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mag_latency got=%b exp=0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || ch(0) !== 20'h00000 || ch(1) !== 20'h00130) begin
            bad++;
            $display("FAIL mag_first got=%b/%h/%h exp=1/00000/00130", out_valid, ch(0), ch(1));
        end
        tick();
        total++;
        if (ch(0) !== 20'h00160 || ch(1) !== 20'h00090) begin
            bad++;
            $display("FAIL mag_second got=%h/%h exp=00160/00090", ch(0), ch(1));
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_signed();
        mode = 2'd1;
        do_seed(16'h0001);
        enable = 1'b1;
        tick();
        total++;
        if (ch(1) !== 20'h00130) begin
            bad++;
            $display("FAIL signed_first got=%h exp=00130", ch(1));
        end
        tick();
        total++;
        if (ch(1) !== 20'hFFF70 || ch(0) !== 20'h00160) begin
            bad++;
            $display("FAIL signed_neg got=%h/%h exp=FFF70/00160", ch(1), ch(0));
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_uniform();
        logic [BW-1:0] exp_u [3];
        exp_u[0] = 20'h00001;
        exp_u[1] = 20'h0B400;
        exp_u[2] = 20'h05A00;
        mode = 2'd2;
        do_seed(16'h0001);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ch(0) !== exp_u[i]) begin
                bad++;
                $display("FAIL uniform_%0d got=%h exp=%h", i, ch(0), exp_u[i]);
            end
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        mode = 2'd0;
        do_seed(16'h0001);
        enable = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || ch(0) !== 20'h00000) begin
                bad++;
                $display("FAIL bp_hold_%0d got=%b/%h exp=1/00000", i, out_valid, ch(0));
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (ch(0) !== 20'h00160) begin
            bad++;
            $display("FAIL bp_release got=%h exp=00160", ch(0));
        end
        tick();
        total++;
        if (ch(0) !== 20'h000B0) begin
            bad++;
            $display("FAIL bp_next got=%h exp=000B0", ch(0));
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_seed_zero();
        do_seed(16'h0000);
        mode   = 2'd2;
        enable = 1'b1;
        tick();
        total++;
        if (ch(0) !== 20'h00001 || ch(1) !== 20'h09E37) begin
            bad++;
            $display("FAIL seed_zero got=%h/%h exp=00001/09E37", ch(0), ch(1));
        end
        enable    = 1'b0;
        tick();
        seed      = 16'h1234;
        rst       = 1'b1;
        seed_load = 1'b1;
        tick();
        rst       = 1'b0;
        seed_load = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL rst_vs_seed_out got=%b/%h exp=0/0", out_valid, out_data);
        end
        enable = 1'b1;
        tick();
        total++;
        if (ch(0) !== 20'h00001 || ch(1) !== 20'h09E36) begin
            bad++;
            $display("FAIL rst_vs_seed_state got=%h/%h exp=00001/09E36", ch(0), ch(1));
        end
        tick();
        seed      = 16'h0001;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        total++;
        if (out_valid !== 1'b0 || ch(0) !== 20'h0B400) begin
            bad++;
            $display("FAIL midstream_drop got=%b/%h exp=0/0B400", out_valid, ch(0));
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || ch(0) !== 20'h00001) begin
            bad++;
            $display("FAIL midstream_resume got=%b/%h exp=1/00001", out_valid, ch(0));
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_lut_write();
        program_lut();
        mode = 2'd0;
        do_seed(16'h0001);
        enable = 1'b1;
        tick();
        lut_we    = 1'b1;
        lut_addr  = 5'd22;
        lut_wdata = 20'hABCDE;
        tick();
        lut_we = 1'b0;
        total++;
        if (ch(0) !== 20'h00160) begin
            bad++;
            $display("FAIL lut_old got=%h exp=00160", ch(0));
        end
        enable = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL enable_drop got=%b exp=0", out_valid);
        end
        do_seed(16'h0001);
        enable = 1'b1;
        tick();
        tick();
        total++;
        if (ch(0) !== 20'hABCDE) begin
            bad++;
            $display("FAIL lut_new got=%h exp=ABCDE", ch(0));
        end
        enable = 1'b0;
        tick();
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom_range(0, 3));
            lut_we    = ($urandom_range(0, 4) == 0);
            lut_addr  = IB'($urandom_range(0, 31));
            lut_wdata = BW'($urandom);
            seed_load = ($urandom_range(0, 40) == 0);
            seed      = 16'($urandom);
            tick();
        end
        enable    = 1'b0;
        lut_we    = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        program_lut();
        test_mag();
        test_signed();
        test_uniform();
        test_backpressure();
        test_seed_zero();
        test_lut_write();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
